irq_requester: RTL and testbench

- Off-chip end of the IRQ/EOI pad protocol: drives `irq[NUM_IRQ-1:0]` into the IRQ pad ring and consumes `eoi[NUM_IRQ-1:0]` from the EOI pads.
- Used as the peripheral-side model/board-FPGA block and in the chip-level bench.
- Per channel: raise `irq` on request, hold it until the SoC answers with `eoi`, drop it, wait for `eoi` to release, then report completion.

---
 rtl/irq_req_pkg.sv | 19 +
 rtl/irq_req_chan.sv | 124 ++++++++++++
 rtl/irq_requester.sv | 124 ++++++++++++
 tb/tb_irq_requester.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_req_pkg.sv
// Shared types and defaults for the irq_requester block.
// The channel state encoding is published both as an enum (for debug and
// tooling) and as plain localparam constants used by the channel FSM.
package irq_req_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_LOW = 2'd2
    } irq_chan_state_e;

    localparam int NUM_IRQ_DEFAULT     = 16;
    localparam int TIMEOUT_CYC_DEFAULT = 1024;

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_ASSERT   = ASSERT;
    localparam logic [1:0] ST_WAIT_LOW = WAIT_LOW;

endpackage

// File: rtl/irq_req_chan.sv
// One irq/eoi channel: eoi synchroniser, IDLE/ASSERT/WAIT_LOW handshake FSM
// and, when IRQ_REQUESTER_TIMEOUT_EN is defined, a saturating ASSERT-time
// counter that forces release after TIMEOUT_CYC cycles without an eoi.
module irq_req_chan
    import irq_req_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic start_i,
    input  logic eoi_i,
    output logic irq_o,
    output logic busy_o,
    output logic eoi_s_o,
    output logic complete_o,
    output logic timed_out_o
);

    logic [SYNC_STAGES-1:0] eoi_sync_q;
    logic                   eoi_s;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   irq_q;
    logic                   timeout_fire;
    logic                   complete;
    logic                   timed_out;

    // Shift the asynchronous eoi pad through the synchroniser chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eoi_sync_q <= '0;
        end else begin
            eoi_sync_q <= {eoi_sync_q[SYNC_STAGES-2:0], eoi_i};
        end
    end

    assign eoi_s = eoi_sync_q[SYNC_STAGES-1];

`ifdef IRQ_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count cycles spent in ASSERT, restarting from zero on every new request.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && start_i) begin
            cnt_d = '0;
        end else if (state_q == ST_ASSERT && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Hold the ASSERT-time counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_fire = (state_q == ST_ASSERT) && (cnt_q == CNT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_fire       = 1'b0;
`endif

    // Next-state logic; a real eoi takes priority over a coincident timeout.
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (eoi_s) begin
                    state_d  = ST_WAIT_LOW;
                    complete = 1'b1;
                end else if (timeout_fire) begin
                    state_d   = ST_WAIT_LOW;
                    complete  = 1'b1;
                    timed_out = 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!eoi_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the state and the irq pad driver together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= (state_d == ST_ASSERT);
        end
    end

    assign irq_o       = irq_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign eoi_s_o     = eoi_s;
    assign complete_o  = complete;
    assign timed_out_o = timed_out;

endmodule

// File: rtl/irq_requester.sv
// Off-chip end of the IRQ/EOI pad protocol. Raises irq per channel on
// request, waits for the SoC's eoi, drops irq, waits for eoi to release and
// then reports completion one channel per cycle, lowest index first.
// Optional forced release on timeout: define IRQ_REQUESTER_TIMEOUT_EN.
module irq_requester
    import irq_req_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int ID_W        = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    input  logic [ID_W-1:0]    req_id,
    output logic               req_ready,
    output logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] eoi,
    output logic [NUM_IRQ-1:0] busy,
    output logic               done_valid,
    output logic [ID_W-1:0]    done_id,
    output logic               done_timeout
);

    logic [NUM_IRQ-1:0] eoi_s;
    logic [NUM_IRQ-1:0] start_vec;
    logic [NUM_IRQ-1:0] complete_vec;
    logic [NUM_IRQ-1:0] timed_out_vec;
    logic [NUM_IRQ-1:0] done_pend_q;
    logic [NUM_IRQ-1:0] done_pend_d;
    logic [NUM_IRQ-1:0] to_pend_q;
    logic [NUM_IRQ-1:0] to_pend_d;
    logic [NUM_IRQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_valid;
    logic               pick_to;
    logic               req_blocked;
    logic               done_valid_q;
    logic [ID_W-1:0]    done_id_q;
    logic               done_timeout_q;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_req_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .start_i     (start_vec[g]),
            .eoi_i       (eoi[g]),
            .irq_o       (irq[g]),
            .busy_o      (busy[g]),
            .eoi_s_o     (eoi_s[g]),
            .complete_o  (complete_vec[g]),
            .timed_out_o (timed_out_vec[g])
        );
    end

    // A channel is ready only when idle and its synced eoi is low (no stale ack).
    always_comb begin
        req_blocked = 1'b1;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req_id == ID_W'(i)) begin
                req_blocked = busy[i] | eoi_s[i];
            end
        end
    end

    assign req_ready = ~req_blocked;

    // Steer an accepted request to its channel.
    always_comb begin
        start_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            start_vec[i] = req_valid && req_ready && (req_id == ID_W'(i));
        end
    end

    // Pick the lowest-index pending completion.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_to     = 1'b0;
        pick_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (done_pend_q[i]) begin
                pick_valid     = 1'b1;
                pick_idx       = ID_W'(i);
                pick_to        = to_pend_q[i];
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
            end
        end
    end

    // Retire the emitted completion and queue any new ones.
    always_comb begin
        done_pend_d = (done_pend_q & ~pick_onehot) | complete_vec;
        to_pend_d   = (to_pend_q & ~pick_onehot) | (complete_vec & timed_out_vec);
    end

    // Register pend vectors and the completion report.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_pend_q    <= '0;
            to_pend_q      <= '0;
            done_valid_q   <= 1'b0;
            done_id_q      <= '0;
            done_timeout_q <= 1'b0;
        end else begin
            done_pend_q    <= done_pend_d;
            to_pend_q      <= to_pend_d;
            done_valid_q   <= pick_valid;
            done_id_q      <= pick_idx;
            done_timeout_q <= pick_valid & pick_to;
        end
    end

    assign done_valid   = done_valid_q;
    assign done_id      = done_id_q;
    assign done_timeout = done_timeout_q;

endmodule

// File: tb/tb_irq_requester.sv
// Self-checking bench for irq_requester (SYNC_STAGES=2, TIMEOUT_CYC=8).
// Table-driven handshake vectors followed by hand-written corner sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_requester;

    localparam int NUM_IRQ = 16;
    localparam int ID_W    = 4;
    localparam int NVEC    = 22;

    typedef struct {
        logic               reqValid;
        logic [ID_W-1:0]    reqId;
        logic [NUM_IRQ-1:0] eoi;
        logic               expReady;
        logic [NUM_IRQ-1:0] expIrq;
        logic [NUM_IRQ-1:0] expBusy;
        logic               expDoneValid;
        logic [ID_W-1:0]    expDoneId;
        logic               expDoneTimeout;
    } vector_t;

    logic               clk;
    logic               rstn;
    logic               reqValid;
    logic [ID_W-1:0]    reqId;
    logic               reqReady;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] eoi;
    logic [NUM_IRQ-1:0] busy;
    logic               doneValid;
    logic [ID_W-1:0]    doneId;
    logic               doneTimeout;

    int checkCount = 0;
    int errorCount = 0;
    int highCycles;
    vector_t vecs[NVEC];

    irq_requester #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (8),
        .ID_W        (ID_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (reqValid),
        .req_id       (reqId),
        .req_ready    (reqReady),
        .irq          (irq),
        .eoi          (eoi),
        .busy         (busy),
        .done_valid   (doneValid),
        .done_id      (doneId),
        .done_timeout (doneTimeout)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        reqValid = v.reqValid;
        reqId    = v.reqId;
        eoi      = v.eoi;
        #1;
        checkOutput($sformatf("row%0d req_ready", idx), 32'(reqReady), 32'(v.expReady));
        @(negedge clk);
        checkOutput($sformatf("row%0d irq", idx), 32'(irq), 32'(v.expIrq));
        checkOutput($sformatf("row%0d busy", idx), 32'(busy), 32'(v.expBusy));
        checkOutput($sformatf("row%0d done_valid", idx), 32'(doneValid), 32'(v.expDoneValid));
        if (v.expDoneValid) begin
            checkOutput($sformatf("row%0d done_id", idx), 32'(doneId), 32'(v.expDoneId));
            checkOutput($sformatf("row%0d done_timeout", idx), 32'(doneTimeout), 32'(v.expDoneTimeout));
        end
    endtask

    initial begin
        rstn     = 1'b0;
        reqValid = 1'b0;
        reqId    = '0;
        eoi      = '0;

        // Channel 3 full handshake, eoi raised the cycle after irq is seen.
        vecs[0]  = '{1'b1, 4'd3,  16'h0000, 1'b1, 16'h0008, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[1]  = '{1'b0, 4'd3,  16'h0008, 1'b0, 16'h0008, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[2]  = '{1'b0, 4'd3,  16'h0008, 1'b0, 16'h0008, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[3]  = '{1'b0, 4'd3,  16'h0008, 1'b0, 16'h0000, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[4]  = '{1'b0, 4'd3,  16'h0008, 1'b0, 16'h0000, 16'h0008, 1'b1, 4'd3,  1'b0};
        vecs[5]  = '{1'b0, 4'd3,  16'h0000, 1'b0, 16'h0000, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[6]  = '{1'b0, 4'd3,  16'h0000, 1'b0, 16'h0000, 16'h0008, 1'b0, 4'd0,  1'b0};
        vecs[7]  = '{1'b0, 4'd3,  16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[8]  = '{1'b0, 4'd3,  16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0,  1'b0};
        // Channels 0, 7, 15 acknowledged together, reported in ascending order.
        vecs[9]  = '{1'b1, 4'd0,  16'h0000, 1'b1, 16'h0001, 16'h0001, 1'b0, 4'd0,  1'b0};
        vecs[10] = '{1'b1, 4'd7,  16'h0000, 1'b1, 16'h0081, 16'h0081, 1'b0, 4'd0,  1'b0};
        vecs[11] = '{1'b1, 4'd15, 16'h0000, 1'b1, 16'h8081, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[12] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h8081, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[13] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h8081, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[14] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h0000, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[15] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h0000, 16'h8081, 1'b1, 4'd0,  1'b0};
        vecs[16] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h0000, 16'h8081, 1'b1, 4'd7,  1'b0};
        vecs[17] = '{1'b0, 4'd15, 16'h8081, 1'b0, 16'h0000, 16'h8081, 1'b1, 4'd15, 1'b0};
        vecs[18] = '{1'b0, 4'd15, 16'h0000, 1'b0, 16'h0000, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[19] = '{1'b0, 4'd15, 16'h0000, 1'b0, 16'h0000, 16'h8081, 1'b0, 4'd0,  1'b0};
        vecs[20] = '{1'b0, 4'd15, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[21] = '{1'b0, 4'd15, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0,  1'b0};

        repeat (3) @(negedge clk);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done_valid", 32'(doneValid), 32'h0);
        checkOutput("reset done_id", 32'(doneId), 32'h0);
        checkOutput("reset done_timeout", 32'(doneTimeout), 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k], k);
        end

        // Stale eoi on channel 5 must hold off a new request.
        reqValid = 1'b0;
        eoi      = 16'h0020;
        repeat (3) @(negedge clk);
        reqValid = 1'b1;
        reqId    = 4'd5;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput($sformatf("stale%0d req_ready", c), 32'(reqReady), 32'h0);
            @(negedge clk);
            checkOutput($sformatf("stale%0d irq5", c), 32'(irq[5]), 32'h0);
        end
        eoi = '0;
        #1;
        checkOutput("stale drop0 req_ready", 32'(reqReady), 32'h0);
        @(negedge clk);
        checkOutput("stale drop1 req_ready", 32'(reqReady), 32'h0);
        checkOutput("stale drop1 irq5", 32'(irq[5]), 32'h0);
        @(negedge clk);
        checkOutput("stale drop2 req_ready", 32'(reqReady), 32'h1);
        checkOutput("stale drop2 irq5", 32'(irq[5]), 32'h0);
        @(negedge clk);
        checkOutput("stale accept irq5", 32'(irq[5]), 32'h1);
        reqValid = 1'b0;

        // Busy channel 9 stalls while channel 2 is still accepted.
        reqValid = 1'b1;
        reqId    = 4'd9;
        #1;
        checkOutput("ch9 first req_ready", 32'(reqReady), 32'h1);
        @(negedge clk);
        checkOutput("ch9 first irq", 32'(irq), 32'h0220);
        #1;
        checkOutput("ch9 busy req_ready", 32'(reqReady), 32'h0);
        @(negedge clk);
        checkOutput("ch9 stalled irq", 32'(irq), 32'h0220);
        checkOutput("ch9 stalled busy", 32'(busy), 32'h0220);
        reqId = 4'd2;
        #1;
        checkOutput("ch2 req_ready", 32'(reqReady), 32'h1);
        @(negedge clk);
        checkOutput("ch2 irq", 32'(irq), 32'h0224);
        reqValid = 1'b0;

        // Reset in the middle of a channel 4 handshake.
        reqValid = 1'b1;
        reqId    = 4'd4;
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("ch4 raised", 32'(irq[4]), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async reset irq", 32'(irq), 32'h0);
        checkOutput("async reset busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post reset%0d done_valid", c), 32'(doneValid), 32'h0);
        end
        reqId = 4'd4;
        #1;
        checkOutput("post reset ch4 req_ready", 32'(reqReady), 32'h1);

        // Channel 1 is never acknowledged.
        reqValid = 1'b1;
        reqId    = 4'd1;
        @(negedge clk);
        reqValid = 1'b0;
`ifdef IRQ_REQUESTER_TIMEOUT_EN
        highCycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (!irq[1]) break;
            highCycles++;
            @(negedge clk);
        end
        checkOutput("timeout irq1 high cycles", 32'(highCycles), 32'd8);
        checkOutput("timeout early done_valid", 32'(doneValid), 32'h0);
        @(negedge clk);
        checkOutput("timeout done_valid", 32'(doneValid), 32'h1);
        checkOutput("timeout done_id", 32'(doneId), 32'd1);
        checkOutput("timeout done_timeout", 32'(doneTimeout), 32'h1);
`else
        highCycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (irq[1]) highCycles++;
            checkOutput($sformatf("hold%0d done_valid", c), 32'(doneValid), 32'h0);
            @(negedge clk);
        end
        checkOutput("no timeout irq1 high cycles", 32'(highCycles), 32'd40);
        checkOutput("no timeout irq1 still high", 32'(irq[1]), 32'h1);
        checkOutput("no timeout done_timeout", 32'(doneTimeout), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
